icmp_echo_responder: RTL and testbench

- Parametrised successor to the single-buffer ICMP echo server on the ping tun/tap path.
- Sits between the tun-side Avalon-ST source and sink and carries raw IPv4 packets, 32-bit beats; byte 0 on the wire is data[7:0].
- Stores each packet, validates it as an ICMPv4 echo request, and replies with swapped addresses, type 0, and an RFC 1624 ones'-complement checksum update.
- Adds an overflow discard, a non-echo policy, full output backpressure and statistics counters. Modifications are applied on the fly at readout, so the buffer infers as RAM.

---
 rtl/icmp_echo_responder.sv | 206 ++++++++++++++++++++
 tb/tb_icmp_echo_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_echo_responder.sv
// ICMPv4 echo responder: buffers one IPv4 packet from an Avalon-ST stream and answers echo
// requests with swapped addresses, type 0 and an incrementally updated checksum.
module icmp_echo_responder #(
   parameter int unsigned MAX_WORDS     = 128,
   parameter int unsigned CNT_W         = 16,
   parameter bit          FORWARD_OTHER = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      stream_in_data,
   input  logic [1:0]       stream_in_empty,
   input  logic             stream_in_valid,
   input  logic             stream_in_startofpacket,
   input  logic             stream_in_endofpacket,
   output logic             stream_in_ready,
   output logic [31:0]      stream_out_data,
   output logic [1:0]       stream_out_empty,
   output logic             stream_out_valid,
   output logic             stream_out_startofpacket,
   output logic             stream_out_endofpacket,
   input  logic             stream_out_ready,
   output logic [CNT_W-1:0] echo_count,
   output logic [CNT_W-1:0] drop_count
);

   localparam int unsigned ADDR_W = $clog2(MAX_WORDS);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] FULL = PTR_W'(MAX_WORDS);

   typedef enum logic [2:0] {StIdle, StRecv, StDiscard, StCheck, StSend} state_e;

   state_e            state_q, state_d;
   logic [31:0]       mem [MAX_WORDS];
   logic [31:0]       rd_data_q;
   logic [PTR_W-1:0]  rx_ptr_q, rx_ptr_d, len_q, len_d;
   logic [ADDR_W-1:0] tx_idx_q, tx_idx_d, rd_log, raddr, waddr;
   logic [1:0]        empty_q, empty_d;
   logic              w0_ok_q, w0_ok_d, w2_ok_q, w2_ok_d, w5_ok_q, w5_ok_d;
   logic              reply_q, reply_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  echo_q, echo_d, drop_q, drop_d;
   logic              we, in_fire, out_fire, tx_last, is_echo;
   logic [15:0]       c_in, c_new;
   logic [16:0]       c_sum;
   logic [31:0]       word;

   assign in_fire  = stream_in_valid && in_ready_q;
   assign out_fire = out_valid_q && stream_out_ready;
   assign tx_last  = {1'b0, tx_idx_q} == (len_q - PTR_W'(1));
   assign is_echo  = (len_q >= PTR_W'(6)) && w0_ok_q && w2_ok_q && w5_ok_q;

   always_comb begin
      state_d     = state_q;
      rx_ptr_d    = rx_ptr_q;
      len_d       = len_q;
      empty_d     = empty_q;
      w0_ok_d     = w0_ok_q;
      w2_ok_d     = w2_ok_q;
      w5_ok_d     = w5_ok_q;
      reply_d     = reply_q;
      out_valid_d = out_valid_q;
      tx_idx_d    = tx_idx_q;
      echo_d      = echo_q;
      drop_d      = drop_q;
      we          = 1'b0;
      waddr       = rx_ptr_q[ADDR_W-1:0];
      unique case (state_q)
         StIdle, StRecv: begin
            if (in_fire) begin
               if (stream_in_startofpacket) begin
                  // SOP always (re)starts a packet at word 0
                  we       = 1'b1;
                  waddr    = '0;
                  rx_ptr_d = PTR_W'(1);
                  w0_ok_d  = stream_in_data[7:0] == 8'h45;
                  state_d  = StRecv;
                  if (stream_in_endofpacket) begin
                     len_d   = PTR_W'(1);
                     empty_d = stream_in_empty;
                     state_d = StCheck;
                  end
               end else if (state_q == StRecv) begin
                  if (rx_ptr_q == FULL) begin
                     if (stream_in_endofpacket) begin
                        drop_d  = drop_q + CNT_W'(1);
                        state_d = StIdle;
                     end else begin
                        state_d = StDiscard;
                     end
                  end else begin
                     we       = 1'b1;
                     rx_ptr_d = rx_ptr_q + PTR_W'(1);
                     if (rx_ptr_q == PTR_W'(2)) w2_ok_d = stream_in_data[15:8] == 8'h01;
                     if (rx_ptr_q == PTR_W'(5)) w5_ok_d = stream_in_data[15:0] == 16'h0008;
                     if (stream_in_endofpacket) begin
                        len_d   = rx_ptr_q + PTR_W'(1);
                        empty_d = stream_in_empty;
                        state_d = StCheck;
                     end
                  end
               end
            end
         end
         StDiscard: begin
            if (in_fire && stream_in_endofpacket) begin
               drop_d  = drop_q + CNT_W'(1);
               state_d = StIdle;
            end
         end
         StCheck: begin
            tx_idx_d    = '0;
            out_valid_d = 1'b0;
            if (is_echo) begin
               reply_d = 1'b1;
               state_d = StSend;
            end else if (FORWARD_OTHER && (len_q != '0)) begin
               reply_d = 1'b0;
               state_d = StSend;
            end else begin
               drop_d  = drop_q + CNT_W'(1);
               state_d = StIdle;
            end
         end
         StSend: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (out_fire) begin
               if (tx_last) begin
                  out_valid_d = 1'b0;
                  state_d     = StIdle;
                  if (reply_q) echo_d = echo_q + CNT_W'(1);
               end else begin
                  tx_idx_d = tx_idx_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
      in_ready_d = (state_d == StIdle) || (state_d == StRecv) || (state_d == StDiscard);
   end

   // Read the word to be shown next cycle; the 3/4 address swap happens on the read address
   always_comb begin
      rd_log = (state_q == StSend && out_fire) ? tx_idx_q + ADDR_W'(1) : tx_idx_q;
      raddr  = rd_log;
      if (reply_q && rd_log == ADDR_W'(3)) raddr = ADDR_W'(4);
      if (reply_q && rd_log == ADDR_W'(4)) raddr = ADDR_W'(3);
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= stream_in_data;
      rd_data_q <= mem[raddr];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         rx_ptr_q    <= '0;
         len_q       <= '0;
         empty_q     <= '0;
         w0_ok_q     <= 1'b0;
         w2_ok_q     <= 1'b0;
         w5_ok_q     <= 1'b0;
         reply_q     <= 1'b0;
         out_valid_q <= 1'b0;
         tx_idx_q    <= '0;
         in_ready_q  <= 1'b0;
         echo_q      <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         rx_ptr_q    <= rx_ptr_d;
         len_q       <= len_d;
         empty_q     <= empty_d;
         w0_ok_q     <= w0_ok_d;
         w2_ok_q     <= w2_ok_d;
         w5_ok_q     <= w5_ok_d;
         reply_q     <= reply_d;
         out_valid_q <= out_valid_d;
         tx_idx_q    <= tx_idx_d;
         in_ready_q  <= in_ready_d;
         echo_q      <= echo_d;
         drop_q      <= drop_d;
      end
   end

   // RFC 1624 update for type 8 -> 0: checksum field stored byte-swapped in word 5
   always_comb begin
      c_in  = {rd_data_q[23:16], rd_data_q[31:24]};
      c_sum = {1'b0, c_in} + 17'h00800;
      c_new = c_sum[15:0] + {15'd0, c_sum[16]};
      word  = rd_data_q;
      if (reply_q && tx_idx_q == ADDR_W'(5)) begin
         word = {c_new[7:0], c_new[15:8], rd_data_q[15:8], 8'h00};
      end
   end

   assign stream_in_ready          = in_ready_q;
   assign stream_out_valid         = out_valid_q;
   assign stream_out_data          = out_valid_q ? word : 32'd0;
   assign stream_out_startofpacket = out_valid_q && (tx_idx_q == '0);
   assign stream_out_endofpacket   = out_valid_q && tx_last;
   assign stream_out_empty         = (out_valid_q && tx_last) ? empty_q : 2'd0;
   assign echo_count               = echo_q;
   assign drop_count               = drop_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// Scoreboard bench: two responders (128 words drop-other, 8 words forward-other) fed the same
// input stream; each output is checked against a packet-level reference model.
module tb_icmp_echo_responder;

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] in_data = '0;
   logic [1:0]  in_empty = '0;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic        in_ready [2];
   logic [31:0] o_data [2];
   logic [1:0]  o_empty [2];
   logic        o_valid [2], o_sop [2], o_eop [2], o_ready [2];
   logic [15:0] echo_cnt [2], drop_cnt [2];

   int          checks = 0, failures = 0;
   beat_t       exp0[$], exp1[$];
   int          exp_echo [2], exp_drop [2], rmode [2];
   logic [31:0] pkt[$];
   logic [1:0]  pkt_empty;
   int          cyc = 0, eop_cyc = 0;
   bit          lat_chk = 1'b0;
   logic [31:0] obs[$];
   logic [1:0]  obs_empty;
   beat_t       prev [2];
   bit          prev_stall [2];
   bit          in_pkt0 = 1'b0, gap0 = 1'b0;

   icmp_echo_responder #(.MAX_WORDS(128), .CNT_W(16), .FORWARD_OTHER(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .stream_in_data(in_data), .stream_in_empty(in_empty), .stream_in_valid(in_valid),
      .stream_in_startofpacket(in_sop), .stream_in_endofpacket(in_eop),
      .stream_in_ready(in_ready[0]),
      .stream_out_data(o_data[0]), .stream_out_empty(o_empty[0]), .stream_out_valid(o_valid[0]),
      .stream_out_startofpacket(o_sop[0]), .stream_out_endofpacket(o_eop[0]),
      .stream_out_ready(o_ready[0]), .echo_count(echo_cnt[0]), .drop_count(drop_cnt[0])
   );

   icmp_echo_responder #(.MAX_WORDS(8), .CNT_W(16), .FORWARD_OTHER(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .stream_in_data(in_data), .stream_in_empty(in_empty), .stream_in_valid(in_valid),
      .stream_in_startofpacket(in_sop), .stream_in_endofpacket(in_eop),
      .stream_in_ready(in_ready[1]),
      .stream_out_data(o_data[1]), .stream_out_empty(o_empty[1]), .stream_out_valid(o_valid[1]),
      .stream_out_startofpacket(o_sop[1]), .stream_out_endofpacket(o_eop[1]),
      .stream_out_ready(o_ready[1]), .echo_count(echo_cnt[1]), .drop_count(drop_cnt[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endfunction

   task automatic fail_stop(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", name);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Reference model: decide the fate of a whole packet from its word list
   task automatic model_push(input int d, input int mw, input bit fwd);
      int          n = pkt.size();
      bit          echo;
      beat_t       b;
      int unsigned c;
      if (n > mw) begin
         exp_drop[d]++;
         return;
      end
      echo = (n >= 6) && pkt[0][7:0] == 8'h45 && pkt[2][15:8] == 8'd1 && pkt[5][15:0] == 16'h0008;
      if (!echo && !fwd) begin
         exp_drop[d]++;
         return;
      end
      if (echo) exp_echo[d]++;
      for (int k = 0; k < n; k++) begin
         b.data = pkt[k];
         if (echo && k == 3) b.data = pkt[4];
         if (echo && k == 4) b.data = pkt[3];
         if (echo && k == 5) begin
            c = {pkt[5][23:16], pkt[5][31:24]};
            c = c + 32'h800;
            if (c > 32'hFFFF) c = c - 32'hFFFF;
            b.data = {c[7:0], c[15:8], pkt[5][15:8], 8'h00};
         end
         b.sop   = (k == 0);
         b.eop   = (k == n - 1);
         b.empty = (k == n - 1) ? pkt_empty : 2'd0;
         if (d == 0) exp0.push_back(b);
         else exp1.push_back(b);
      end
   endtask

   task automatic build_echo(input int n, input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] csum, input logic [1:0] e);
      pkt.delete();
      for (int k = 0; k < n; k++) pkt.push_back($urandom);
      pkt[0][7:0]  = 8'h45;
      pkt[2][15:8] = 8'h01;
      pkt[3]       = src;
      pkt[4]       = dst;
      pkt[5]       = {csum[7:0], csum[15:8], 8'h00, 8'h08};
      pkt_empty    = e;
   endtask

   task automatic drive_beat(input logic [31:0] d, input bit sop, input bit eop,
                             input logic [1:0] e);
      int budget = 0;
      if ($urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      while (!(in_ready[0] && in_ready[1])) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
         budget++;
         if (budget > 3000) fail_stop("input_ready_wait");
      end
      in_data  = d;
      in_sop   = sop;
      in_eop   = eop;
      in_empty = e;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_empty = 2'd0;
   endtask

   task automatic send_pkt();
      int n = pkt.size();
      for (int k = 0; k < n; k++)
         drive_beat(pkt[k], k == 0, k == n - 1, (k == n - 1) ? pkt_empty : 2'd0);
      eop_cyc = cyc;
      model_push(0, 128, 1'b0);
      model_push(1, 8, 1'b1);
   endtask

   task automatic drain();
      int budget = 0;
      while (exp0.size() != 0 || exp1.size() != 0 || !(in_ready[0] && in_ready[1])) begin
         @(posedge clk);
         #1;
         budget++;
         if (budget > 3000) fail_stop("drain_wait");
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_counters(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_echo_count%0d", tag, i), 64'(echo_cnt[i]), 64'(exp_echo[i][15:0]));
         chk($sformatf("%s_drop_count%0d", tag, i), 64'(drop_cnt[i]), 64'(exp_drop[i][15:0]));
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_outputs%0d", tag, i),
             64'({o_valid[i], o_sop[i], o_eop[i], o_empty[i], o_data[i]}), 64'd0);
         chk($sformatf("%s_in_ready%0d", tag, i), 64'(in_ready[i]), 64'd0);
         chk($sformatf("%s_counters%0d", tag, i), 64'({echo_cnt[i], drop_cnt[i]}), 64'd0);
      end
   endtask

   // Sink ready: 0 = held high, 1 = random 50%, 2 = held low
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
         o_ready[i] = (rmode[i] == 0) ? 1'b1 : (rmode[i] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
   end

   // Monitor: pops the scoreboard on every accepted output beat
   always @(negedge clk) begin
      beat_t cur, e;
      if (!reset_n) begin
         prev_stall[0] = 1'b0;
         prev_stall[1] = 1'b0;
         in_pkt0 = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            cur = {o_data[i], o_sop[i], o_eop[i], o_empty[i]};
            if (prev_stall[i])
               chk($sformatf("stall_stable%0d", i), 64'({o_valid[i], cur}), 64'({1'b1, prev[i]}));
            if (o_valid[i] && o_ready[i]) begin
               if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat%0d actual=%h expected=none", i, cur);
               end else begin
                  if (i == 0) e = exp0.pop_front();
                  else e = exp1.pop_front();
                  chk($sformatf("beat%0d", i), 64'(cur), 64'(e));
               end
               if (i == 0) begin
                  if (cur.sop) begin
                     obs.delete();
                     in_pkt0 = 1'b1;
                     gap0 = 1'b0;
                     if (lat_chk) chk("first_valid_latency", 64'(cyc - eop_cyc), 64'd2);
                  end
                  obs.push_back(cur.data);
                  if (cur.eop) begin
                     obs_empty = cur.empty;
                     in_pkt0 = 1'b0;
                     if (lat_chk) chk("contiguous_output", 64'(gap0), 64'd0);
                  end
               end
            end else if (i == 0 && in_pkt0 && !o_valid[0]) begin
               gap0 = 1'b1;
            end
            prev_stall[i] = o_valid[i] && !o_ready[i];
            prev[i] = cur;
         end
      end
   end

   initial begin
      #500000;
      fail_stop("global_watchdog");
   end

   initial begin
      int kind, n;
      rmode[0] = 0; rmode[1] = 0;
      o_ready[0] = 1'b1; o_ready[1] = 1'b1;
      exp_echo[0] = 0; exp_echo[1] = 0; exp_drop[0] = 0; exp_drop[1] = 0;
      #2 reset_n = 1'b0;
      #1 check_reset_state("reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // 21-word echo request, contiguous output and latency
      lat_chk = 1'b1;
      build_echo(21, 32'h0A000001, 32'h0A000002, 16'h1234, 2'd2);
      send_pkt();
      drain();
      lat_chk = 1'b0;
      chk("echo_beats", 64'(obs.size()), 64'd21);
      chk("echo_word3", 64'(obs[3]), 64'h0A000002);
      chk("echo_word4", 64'(obs[4]), 64'h0A000001);
      chk("echo_word5", 64'(obs[5]), 64'h341A0000);
      chk("echo_last_empty", 64'(obs_empty), 64'd2);
      check_counters("echo");

      // Checksum end-around carry
      build_echo(6, $urandom, $urandom, 16'hF7FF, 2'd0);
      send_pkt();
      drain();
      chk("carry_f7ff", 64'(obs[5]), 64'hFFFF0000);
      build_echo(6, $urandom, $urandom, 16'hF800, 2'd1);
      send_pkt();
      drain();
      chk("carry_f800", 64'(obs[5]), 64'h01000000);

      // Non-echo (UDP): dropped by dut0, forwarded by dut1
      build_echo(8, $urandom, $urandom, 16'hABCD, 2'd3);
      pkt[2][15:8] = 8'd17;
      send_pkt();
      drain();
      check_counters("non_echo");

      // Overflow on the 8-word instance, then a valid short echo
      build_echo(12, 32'hC0A80001, 32'hC0A80002, 16'h5555, 2'd0);
      send_pkt();
      build_echo(6, 32'hC0A80003, 32'hC0A80004, 16'h0102, 2'd0);
      send_pkt();
      drain();
      check_counters("overflow");

      // Stray beat, abandoned packet, then restart on SOP
      drive_beat($urandom, 1'b0, 1'b0, 2'd0);
      build_echo(7, 32'h11111111, 32'h22222222, 16'h3333, 2'd0);
      for (int k = 0; k < 4; k++) drive_beat(pkt[k], k == 0, 1'b0, 2'd0);
      build_echo(7, 32'h44444444, 32'h55555555, 16'h6666, 2'd1);
      send_pkt();
      drain();
      check_counters("restart");

      // Random mix under random backpressure
      rmode[0] = 1; rmode[1] = 1;
      for (int p = 0; p < 20; p++) begin
         kind = $urandom_range(0, 3);
         n = (kind == 2) ? $urandom_range(2, 5) : $urandom_range(6, 14);
         if (kind == 2) begin
            pkt.delete();
            for (int k = 0; k < n; k++) pkt.push_back($urandom);
            pkt[0][7:0] = 8'h45;
            pkt_empty = 2'($urandom_range(0, 3));
         end else begin
            build_echo(n, $urandom, $urandom, 16'($urandom), 2'($urandom_range(0, 3)));
            if (kind == 1) pkt[2][15:8] = 8'($urandom_range(2, 255));
            if (kind == 3) pkt[0][7:0] = 8'h46;
         end
         send_pkt();
      end
      drain();
      check_counters("random");

      // Reset while dut0 is stalled in the middle of a reply
      rmode[0] = 2; rmode[1] = 1;
      build_echo(21, $urandom, $urandom, 16'h0F0F, 2'd0);
      send_pkt();
      n = 0;
      while (!o_valid[0]) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 100) fail_stop("send_start_wait");
      end
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_reset_state("mid_send_reset");
      exp0.delete(); exp1.delete();
      exp_echo[0] = 0; exp_echo[1] = 0; exp_drop[0] = 0; exp_drop[1] = 0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      rmode[0] = 0; rmode[1] = 0;
      build_echo(6, 32'h0A0000FE, 32'h0A0000FD, 16'h2222, 2'd0);
      send_pkt();
      drain();
      check_counters("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
